// File: rtl/simmem_pkg.sv
// Shared types and timing constants for the simulated memory controller.
package simmem_pkg;

    localparam int unsigned AddrWidth              = 16;
    localparam int unsigned RowBufferLenWidth      = 8;
    localparam int unsigned RowWidth               = AddrWidth - RowBufferLenWidth;
    localparam int unsigned BurstLenWidth          = 8;
    localparam int unsigned IdWidth                = 4;
    localparam int unsigned WriteRespBankAddrWidth = 4;
    localparam int unsigned ReadDataBankAddrWidth  = 4;

    localparam int unsigned RowHitCost     = 10;
    localparam int unsigned PrechargeCost  = 50;
    localparam int unsigned ActivationCost = 45;
    localparam int unsigned CostWidth      = 9;

    typedef logic [WriteRespBankAddrWidth-1:0] write_iid_t;
    typedef logic [ReadDataBankAddrWidth-1:0]  read_iid_t;

    typedef struct packed {
        logic [IdWidth-1:0]       id;
        logic [AddrWidth-1:0]     addr;
        logic [BurstLenWidth-1:0] burst_length;
        logic [2:0]               burst_size;
        logic [1:0]               burst_type;
    } waddr_t;

    typedef struct packed {
        logic [IdWidth-1:0]       id;
        logic [AddrWidth-1:0]     addr;
        logic [BurstLenWidth-1:0] burst_length;
        logic [2:0]               burst_size;
        logic [1:0]               burst_type;
    } raddr_req_t;

    typedef enum logic [1:0] {IDLE, COUNT, RELEASE} delay_calc_state_e;

endpackage

// File: rtl/simmem_row_cost.sv
// Service cost of one access against a single bank's row buffer.
module simmem_row_cost
    import simmem_pkg::*;
#(
    parameter int unsigned RowHitCost     = simmem_pkg::RowHitCost,
    parameter int unsigned PrechargeCost  = simmem_pkg::PrechargeCost,
    parameter int unsigned ActivationCost = simmem_pkg::ActivationCost,
    parameter int unsigned CostWidth      = simmem_pkg::CostWidth
) (
    input  logic                     row_open_i,
    input  logic [RowWidth-1:0]      open_row_i,
    input  logic [AddrWidth-1:0]     addr_i,
    input  logic [BurstLenWidth-1:0] burst_length_i,
    output logic [CostWidth-1:0]     cost_o,
    output logic [RowWidth-1:0]      row_o
);

    localparam logic [CostWidth-1:0] HitCost      = CostWidth'(RowHitCost);
    localparam logic [CostWidth-1:0] ClosedCost   = CostWidth'(ActivationCost + RowHitCost);
    localparam logic [CostWidth-1:0] ConflictCost =
        CostWidth'(PrechargeCost + ActivationCost + RowHitCost);

    logic [CostWidth-1:0] base_cost;

    assign row_o = addr_i[AddrWidth-1:RowBufferLenWidth];

    always_comb begin
        base_cost = ConflictCost;
        if (!row_open_i) begin
            base_cost = ClosedCost;
        end else if (open_row_i == row_o) begin
            base_cost = HitCost;
        end
    end

    assign cost_o = base_cost + CostWidth'(burst_length_i);

endmodule

// File: rtl/simmem_delay_calculator.sv
// Single-bank delay model: accepts one address request at a time and
// releases its iid to the owning response bank once the access cost elapses.
module simmem_delay_calculator
    import simmem_pkg::*;
#(
    parameter int unsigned RowHitCost     = simmem_pkg::RowHitCost,
    parameter int unsigned PrechargeCost  = simmem_pkg::PrechargeCost,
    parameter int unsigned ActivationCost = simmem_pkg::ActivationCost,
    parameter int unsigned CostWidth      = simmem_pkg::CostWidth
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              waddr_valid_i,
    output logic                              waddr_ready_o,
    input  logic [$bits(waddr_t)-1:0]         waddr_i,
    input  logic [WriteRespBankAddrWidth-1:0] waddr_iid_i,
    input  logic                              raddr_valid_i,
    output logic                              raddr_ready_o,
    input  logic [$bits(raddr_req_t)-1:0]     raddr_i,
    input  logic [ReadDataBankAddrWidth-1:0]  raddr_iid_i,
    output logic                              wrelease_valid_o,
    output logic [WriteRespBankAddrWidth-1:0] wrelease_iid_o,
    input  logic                              wrelease_ready_i,
    output logic                              rrelease_valid_o,
    output logic [ReadDataBankAddrWidth-1:0]  rrelease_iid_o,
    input  logic                              rrelease_ready_i
);

    delay_calc_state_e state_q, state_d;
    logic                 ptr_q, ptr_d;          // 0: write wins contention, 1: read
    logic                 row_open_q, row_open_d;
    logic [RowWidth-1:0]  open_row_q, open_row_d;
    logic [CostWidth-1:0] cnt_q, cnt_d;
    logic                 dir_w_q, dir_w_d;
    write_iid_t           wiid_q, wiid_d;
    read_iid_t            riid_q, riid_d;

    waddr_t     wreq;
    raddr_req_t rreq;
    logic       grant_w, grant_r, handshake, rel_fire;
    logic [AddrWidth-1:0]     sel_addr;
    logic [BurstLenWidth-1:0] sel_len;
    logic [CostWidth-1:0]     cost;
    logic [RowWidth-1:0]      new_row;
    logic                     unused_req_fields;

    assign wreq = waddr_t'(waddr_i);
    assign rreq = raddr_req_t'(raddr_i);
    assign unused_req_fields = ^{wreq.id, wreq.burst_size, wreq.burst_type,
                                 rreq.id, rreq.burst_size, rreq.burst_type};

    assign grant_w = waddr_valid_i & (~raddr_valid_i | ~ptr_q);
    assign grant_r = raddr_valid_i & (~waddr_valid_i | ptr_q);

    assign waddr_ready_o = (state_q == IDLE) & grant_w;
    assign raddr_ready_o = (state_q == IDLE) & grant_r;
    assign handshake     = waddr_ready_o | raddr_ready_o;

    assign sel_addr = grant_w ? wreq.addr : rreq.addr;
    assign sel_len  = grant_w ? wreq.burst_length : rreq.burst_length;

    simmem_row_cost #(
        .RowHitCost     (RowHitCost),
        .PrechargeCost  (PrechargeCost),
        .ActivationCost (ActivationCost),
        .CostWidth      (CostWidth)
    ) u_row_cost (
        .row_open_i     (row_open_q),
        .open_row_i     (open_row_q),
        .addr_i         (sel_addr),
        .burst_length_i (sel_len),
        .cost_o         (cost),
        .row_o          (new_row)
    );

    assign wrelease_valid_o = (state_q == RELEASE) & dir_w_q;
    assign rrelease_valid_o = (state_q == RELEASE) & ~dir_w_q;
    assign wrelease_iid_o   = wiid_q;
    assign rrelease_iid_o   = riid_q;
    assign rel_fire = (wrelease_valid_o & wrelease_ready_i) |
                      (rrelease_valid_o & rrelease_ready_i);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        row_open_d = row_open_q;
        open_row_d = open_row_q;
        cnt_d      = cnt_q;
        dir_w_d    = dir_w_q;
        wiid_d     = wiid_q;
        riid_d     = riid_q;
        unique case (state_q)
            IDLE: begin
                if (handshake) begin
                    dir_w_d    = grant_w;
                    if (grant_w) wiid_d = waddr_iid_i;
                    else         riid_d = raddr_iid_i;
                    // cost-1 here plus reaching zero one cycle early puts
                    // the first release cycle exactly cost cycles later
                    cnt_d      = cost - CostWidth'(1);
                    row_open_d = 1'b1;
                    open_row_d = new_row;
                    if (waddr_valid_i && raddr_valid_i) ptr_d = ~ptr_q;
                    state_d    = COUNT;
                end
            end
            COUNT: begin
                cnt_d = cnt_q - CostWidth'(1);
                if (cnt_d == '0) state_d = RELEASE;
            end
            RELEASE: begin
                if (rel_fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            row_open_q <= 1'b0;
            open_row_q <= '0;
            cnt_q      <= '0;
            dir_w_q    <= 1'b0;
            wiid_q     <= '0;
            riid_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            row_open_q <= row_open_d;
            open_row_q <= open_row_d;
            cnt_q      <= cnt_d;
            dir_w_q    <= dir_w_d;
            wiid_q     <= wiid_d;
            riid_q     <= riid_d;
        end
    end

endmodule

// File: tb/tb_simmem_delay_calculator.sv
// Self-checking bench for the single-bank delay calculator.
module tb_simmem_delay_calculator;
    import simmem_pkg::*;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    logic                              rst_i;
    logic                              waddr_valid_i, waddr_ready_o;
    logic [$bits(waddr_t)-1:0]         waddr_i;
    logic [WriteRespBankAddrWidth-1:0] waddr_iid_i;
    logic                              raddr_valid_i, raddr_ready_o;
    logic [$bits(raddr_req_t)-1:0]     raddr_i;
    logic [ReadDataBankAddrWidth-1:0]  raddr_iid_i;
    logic                              wrelease_valid_o, wrelease_ready_i;
    logic [WriteRespBankAddrWidth-1:0] wrelease_iid_o;
    logic                              rrelease_valid_o, rrelease_ready_i;
    logic [ReadDataBankAddrWidth-1:0]  rrelease_iid_o;

    simmem_delay_calculator dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .waddr_valid_i(waddr_valid_i), .waddr_ready_o(waddr_ready_o),
        .waddr_i(waddr_i), .waddr_iid_i(waddr_iid_i),
        .raddr_valid_i(raddr_valid_i), .raddr_ready_o(raddr_ready_o),
        .raddr_i(raddr_i), .raddr_iid_i(raddr_iid_i),
        .wrelease_valid_o(wrelease_valid_o), .wrelease_iid_o(wrelease_iid_o),
        .wrelease_ready_i(wrelease_ready_i),
        .rrelease_valid_o(rrelease_valid_o), .rrelease_iid_o(rrelease_iid_o),
        .rrelease_ready_i(rrelease_ready_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit          is_w;
        logic [15:0] addr;
        logic [7:0]  len;
        logic [3:0]  iid;
        int          exp_cost;
    } vec_t;

    // Behavioural row-buffer model: one open row, cost from the three cases.
    bit         m_open;
    logic [7:0] m_row;

    function automatic int model_cost(input logic [15:0] addr, input logic [7:0] len);
        logic [7:0] r;
        r = addr[15:8];
        if (!m_open)        return 55 + int'(len);
        else if (r == m_row) return 10 + int'(len);
        else                return 105 + int'(len);
    endfunction

    task automatic drive_req(input bit is_w, input logic [15:0] addr,
                             input logic [7:0] len, input logic [3:0] iid);
        waddr_t w;
        w = '0;
        w.id = 4'($urandom);
        w.addr = addr;
        w.burst_length = len;
        w.burst_size = 3'd2;
        w.burst_type = 2'($urandom);
        if (is_w) begin
            waddr_i = w; waddr_iid_i = iid; waddr_valid_i = 1'b1;
        end else begin
            raddr_i = w; raddr_iid_i = iid; raddr_valid_i = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        waddr_valid_i = 1'b0;
        raddr_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        m_open = 1'b0;
    endtask

    // Waits for the handshake; returns its cycle or -1 on timeout.
    task automatic accept(input bit is_w, input string name, output int hs);
        hs = -1;
        for (int i = 0; i < 1000; i++) begin
            #1;
            if (is_w ? waddr_ready_o : raddr_ready_o) begin
                hs = cyc;
                break;
            end
            @(negedge clk_i);
        end
        if (hs < 0) chk({name, "_accept_timeout"}, 1, 0);
        @(negedge clk_i);
        waddr_valid_i = 1'b0;
        raddr_valid_i = 1'b0;
    endtask

    task automatic wait_release(input bit is_w, input string name, output int rel);
        rel = -1;
        for (int i = 0; i < 1000; i++) begin
            if (is_w ? wrelease_valid_o : rrelease_valid_o) begin
                rel = cyc;
                break;
            end
            @(negedge clk_i);
        end
        if (rel < 0) chk({name, "_release_timeout"}, 1, 0);
    endtask

    task automatic run_req(input bit is_w, input logic [15:0] addr, input logic [7:0] len,
                           input logic [3:0] iid, input int exp_cost, input string name);
        int hs, rel;
        @(negedge clk_i);
        drive_req(is_w, addr, len, iid);
        accept(is_w, name, hs);
        if (hs < 0) return;
        wait_release(is_w, name, rel);
        if (rel < 0) return;
        chk({name, "_latency"}, rel - hs, exp_cost);
        chk({name, "_iid"}, is_w ? wrelease_iid_o : rrelease_iid_o, iid);
        chk({name, "_other_rel"}, is_w ? rrelease_valid_o : wrelease_valid_o, 0);
    endtask

    vec_t vecs[$];

    initial begin
        int hs, rel, got, seen;
        bit stable_ok;
        logic [7:0] rows [3];

        rst_i = 1'b1;
        waddr_valid_i = 1'b0; raddr_valid_i = 1'b0;
        waddr_i = '0; raddr_i = '0; waddr_iid_i = '0; raddr_iid_i = '0;
        wrelease_ready_i = 1'b1; rrelease_ready_i = 1'b1;
        m_open = 1'b0; m_row = '0;

        vecs.push_back('{1'b1, 16'h1234, 8'd0,   4'd5, 55});
        vecs.push_back('{1'b1, 16'h12FF, 8'd3,   4'd6, 13});
        vecs.push_back('{1'b0, 16'h3400, 8'd0,   4'd2, 105});
        vecs.push_back('{1'b0, 16'h3410, 8'd0,   4'd3, 10});
        vecs.push_back('{1'b1, 16'hABCD, 8'd255, 4'd7, 360});
        vecs.push_back('{1'b0, 16'hAB00, 8'd255, 4'd8, 265});

        do_reset();
        #1;
        chk("rst_wready", waddr_ready_o, 0);
        chk("rst_rready", raddr_ready_o, 0);
        chk("rst_wrel_valid", wrelease_valid_o, 0);
        chk("rst_rrel_valid", rrelease_valid_o, 0);

        foreach (vecs[i])
            run_req(vecs[i].is_w, vecs[i].addr, vecs[i].len, vecs[i].iid,
                    vecs[i].exp_cost, $sformatf("vec%0d", i));

        // Contention from reset: write, then read, then write; never both ready.
        do_reset();
        @(negedge clk_i);
        drive_req(1'b1, 16'h1000, 8'd0, 4'd1);
        drive_req(1'b0, 16'h2000, 8'd0, 4'd2);
        seen = 0;
        for (int i = 0; i < 2000 && seen < 3; i++) begin
            #1;
            chk("ready_exclusive", waddr_ready_o & raddr_ready_o, 0);
            if (waddr_ready_o || raddr_ready_o) begin
                got = waddr_ready_o ? 1 : 0;
                chk($sformatf("rr_order%0d", seen), got, (seen == 1) ? 0 : 1);
                seen++;
            end
            @(negedge clk_i);
        end
        chk("rr_grants", seen, 3);
        waddr_valid_i = 1'b0; raddr_valid_i = 1'b0;

        // Release backpressure: stall 20 cycles, row state unaffected.
        do_reset();
        #1;
        chk("rst2_wiid", wrelease_iid_o, 0);
        chk("rst2_riid", rrelease_iid_o, 0);
        wrelease_ready_i = 1'b0;
        @(negedge clk_i);
        drive_req(1'b1, 16'h5000, 8'd0, 4'd9);
        accept(1'b1, "stall", hs);
        wait_release(1'b1, "stall", rel);
        chk("stall_latency", rel - hs, 55);
        stable_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_req(1'b0, 16'h6000, 8'd0, 4'd1);
            #1;
            if (!wrelease_valid_o || wrelease_iid_o != 4'd9 || raddr_ready_o || waddr_ready_o)
                stable_ok = 1'b0;
            @(negedge clk_i);
        end
        raddr_valid_i = 1'b0;
        chk("stall_stable", stable_ok, 1);
        wrelease_ready_i = 1'b1;
        @(negedge clk_i);
        chk("stall_released", wrelease_valid_o, 0);
        run_req(1'b1, 16'h5010, 8'd0, 4'd10, 10, "after_stall_hit");

        // Reset in the middle of counting drops the request and closes the row.
        @(negedge clk_i);
        drive_req(1'b1, 16'h7700, 8'd50, 4'd4);
        accept(1'b1, "midrst", hs);
        repeat (20) @(negedge clk_i);
        do_reset();
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (wrelease_valid_o || rrelease_valid_o) seen++;
            @(negedge clk_i);
        end
        chk("midrst_no_release", seen, 0);
        run_req(1'b1, 16'h7700, 8'd0, 4'd3, 55, "midrst_closed");

        // Random traffic against the behavioural row model.
        do_reset();
        rows[0] = 8'h12; rows[1] = 8'h34; rows[2] = 8'h56;
        for (int i = 0; i < 16; i++) begin
            bit          is_w;
            logic [15:0] a;
            logic [7:0]  l;
            int          c;
            is_w = 1'($urandom);
            a = {rows[$urandom_range(0, 2)], 8'($urandom)};
            l = 8'($urandom_range(0, 20));
            c = model_cost(a, l);
            m_open = 1'b1;
            m_row = a[15:8];
            run_req(is_w, a, l, 4'($urandom), c, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
